fetch_queue: RTL

//  Decoupled instruction-fetch front end for the 5-stage core: replaces the direct pc -> instruction_mem -> if_id path.

---
 rtl/cpu_pkg.sv | 7 +
 rtl/fetch_fifo.sv | 45 ++++
 rtl/fetch_queue.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants for the core front end: default widths, the canonical NOP and the PC increment.
package cpu_pkg;
  localparam int unsigned XLEN = 32;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int unsigned PC_STEP = 4;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instr} entries for the fetch queue; flush empties it in one cycle.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      used;

  // Extra pointer MSB distinguishes full (MSBs differ) from empty (pointers equal).
  assign used  = wr_ptr_q - rd_ptr_q;
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign count = used;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        wr_ptr_q                <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end
endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: sequential requests, in-order responses buffered in a FIFO for ID,
// with redirect flushing the queue and dropping responses still in flight.
module fetch_queue #(
  parameter int unsigned          XLEN     = cpu_pkg::XLEN,
  parameter int unsigned          DEPTH    = 4,
  parameter int unsigned          MAX_OUT  = 2,
  parameter logic [XLEN-1:0]      RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            pause,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr
);
  import cpu_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned EW = XLEN + INSTR_W;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [XLEN-1:0] target_pc;
  logic [OW-1:0]   live_out_q, live_out_d;
  logic [OW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic            full, empty;
  logic            can_buffer, can_track;
  logic            issue, live_rsp, drop_rsp, push, pop;

  assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};
  assign live_rsp  = imem_rsp_valid && (drop_cnt_q == '0);
  assign drop_rsp  = imem_rsp_valid && (drop_cnt_q != '0);

  // Queue slots are reserved at issue time so a live response can never find the queue full.
  assign can_buffer = (32'(count) + 32'(live_out_q)) < DEPTH;
  assign can_track  = (32'(live_out_q) + 32'(drop_cnt_q)) < MAX_OUT;

  assign imem_req_valid = !rst && !redirect && can_buffer && can_track;
  assign imem_req_addr  = fetch_pc_q;
  assign issue          = imem_req_valid && imem_req_ready;

  assign id_valid = !rst && !empty;
  assign id_pc    = id_valid ? head[EW-1 -: XLEN] : '0;
  assign id_instr = id_valid ? head[INSTR_W-1:0] : NOP_INSTR;

  assign push = live_rsp && !redirect;
  assign pop  = id_valid && !pause && !redirect;

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({resp_pc_q, imem_rsp_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    live_out_d = live_out_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      live_out_d = '0;
      // Every outstanding request becomes a drop, less the one whose response arrives now.
      drop_cnt_d = drop_cnt_q + live_out_q - OW'(imem_rsp_valid);
    end else begin
      if (issue) begin
        fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      end
      if (live_rsp) begin
        resp_pc_d = resp_pc_q + XLEN'(PC_STEP);
      end
      live_out_d = live_out_q + OW'(issue) - OW'(live_rsp);
      drop_cnt_d = drop_cnt_q - OW'(drop_rsp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      live_out_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      live_out_q <= live_out_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full));
    end
  end
endmodule
